// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline
// writeback, MDU and LSU; tracks long-latency destinations in a busy scoreboard.
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    pipe_valid,
    input  logic [RADDR_W-1:0]      pipe_rd,
    input  logic [XLEN-1:0]         pipe_data,
    input  logic                    mdu_valid,
    input  logic [RADDR_W-1:0]      mdu_rd,
    input  logic [XLEN-1:0]         mdu_data,
    output logic                    mdu_ready,
    input  logic                    lsu_valid,
    input  logic [RADDR_W-1:0]      lsu_rd,
    input  logic [XLEN-1:0]         lsu_data,
    output logic                    lsu_ready,
    input  logic                    issue_valid,
    input  logic [RADDR_W-1:0]      issue_rd,
    output logic [2**RADDR_W-1:0]   busy,
    output logic                    pipe_hold,
    output logic                    rf_we,
    output logic [RADDR_W-1:0]      rf_rd,
    output logic [XLEN-1:0]         rf_wdata
);

    localparam int NREG  = 2**RADDR_W;
    localparam int CNT_W = $clog2(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX - 1);

    typedef enum logic {
        RR_MDU = 1'b0,
        RR_LSU = 1'b1
    } rr_e;

    rr_e                rr_q, rr_d;
    logic [NREG-1:0]    busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hold_q, hold_d;
    logic               we_q, we_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]    data_q, data_d;

    logic gnt_pipe, gnt_mdu, gnt_lsu;
    logic long_gnt, denied;

    always_comb begin
        gnt_pipe = pipe_valid;
        gnt_mdu  = 1'b0;
        gnt_lsu  = 1'b0;
        if (!pipe_valid) begin
            unique case ({mdu_valid, lsu_valid})
                2'b10:   gnt_mdu = 1'b1;
                2'b01:   gnt_lsu = 1'b1;
                2'b11: begin
                    gnt_mdu = (rr_q == RR_MDU);
                    gnt_lsu = (rr_q == RR_LSU);
                end
                default: ;
            endcase
        end
    end

    assign long_gnt  = gnt_mdu | gnt_lsu;
    assign denied    = (mdu_valid | lsu_valid) & ~long_gnt;
    assign mdu_ready = gnt_mdu;
    assign lsu_ready = gnt_lsu;

    // x0 grants still move rd/data but never raise the write enable
    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        unique case (1'b1)
            gnt_pipe: begin
                rd_d   = pipe_rd;
                data_d = pipe_data;
            end
            gnt_mdu: begin
                rd_d   = mdu_rd;
                data_d = mdu_data;
            end
            gnt_lsu: begin
                rd_d   = lsu_rd;
                data_d = lsu_data;
            end
            default: ;
        endcase
        we_d = (gnt_pipe | long_gnt) & (rd_d != '0);
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_mdu) rr_d = RR_LSU;
        if (gnt_lsu) rr_d = RR_MDU;
    end

    // clear first so a same-cycle issue to the same register wins
    always_comb begin
        busy_d = busy_q;
        if (gnt_mdu) busy_d[mdu_rd] = 1'b0;
        if (gnt_lsu) busy_d[lsu_rd] = 1'b0;
        if (issue_valid) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d  = cnt_q;
        hold_d = hold_q;
        if (long_gnt) begin
            cnt_d  = '0;
            hold_d = 1'b0;
        end else if (denied) begin
            if (cnt_q == CNT_MAX) hold_d = 1'b1;
            else                  cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q   <= RR_MDU;
            busy_q <= '0;
            cnt_q  <= '0;
            hold_q <= 1'b0;
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            rr_q   <= rr_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign busy      = busy_q;
    assign pipe_hold = hold_q;
    assign rf_we     = we_q;
    assign rf_rd     = rd_q;
    assign rf_wdata  = data_q;

    a_hold_contract: assert property (
        @(posedge clk) disable iff (!rstn) !(pipe_hold && pipe_valid)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter with a behavioural
// model feeding an expected-response queue checked by a monitor.
module tb_wb_port_arbiter;

    localparam int XLEN       = 32;
    localparam int RADDR_W    = 5;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              pipe_valid = 0;
    logic [4:0]        pipe_rd = 0;
    logic [31:0]       pipe_data = 0;
    logic              mdu_valid = 0;
    logic [4:0]        mdu_rd = 0;
    logic [31:0]       mdu_data = 0;
    logic              mdu_ready;
    logic              lsu_valid = 0;
    logic [4:0]        lsu_rd = 0;
    logic [31:0]       lsu_data = 0;
    logic              lsu_ready;
    logic              issue_valid = 0;
    logic [4:0]        issue_rd = 0;
    logic [31:0]       busy;
    logic              pipe_hold;
    logic              rf_we;
    logic [4:0]        rf_rd;
    logic [31:0]       rf_wdata;

    wb_port_arbiter #(
        .XLEN(XLEN), .RADDR_W(RADDR_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rstn(rstn),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy(busy), .pipe_hold(pipe_hold),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] busy;
        bit          hold;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   fails  = 0;

    // model: winner of the last long grant, unbounded denial run length
    bit          m_last_lsu;
    logic [31:0] m_busy;
    int          m_run;
    bit          m_hold;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_win;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last_lsu = 1'b1;
        m_busy = '0;
        m_run  = 0;
        m_hold = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_win  = 0;
    endtask

    task automatic model_step();
        exp_t e;
        logic [4:0] wrd;
        if (pipe_valid)                  m_win = 1;
        else if (mdu_valid && lsu_valid) m_win = m_last_lsu ? 2 : 3;
        else if (mdu_valid)              m_win = 2;
        else if (lsu_valid)              m_win = 3;
        else                             m_win = 0;
        chk("mdu_ready", {31'b0, mdu_ready}, {31'b0, m_win == 2});
        chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, m_win == 3});
        e.we = 1'b0;
        wrd = '0;
        if (m_win == 1) begin wrd = pipe_rd; m_data = pipe_data; end
        if (m_win == 2) begin wrd = mdu_rd;  m_data = mdu_data;  end
        if (m_win == 3) begin wrd = lsu_rd;  m_data = lsu_data;  end
        if (m_win != 0) begin
            m_rd = wrd;
            e.we = (wrd != 0);
        end
        if (m_win >= 2) begin
            m_last_lsu = (m_win == 3);
            if (wrd != 0) m_busy[wrd] = 1'b0;
            m_run  = 0;
            m_hold = 1'b0;
        end else if (mdu_valid || lsu_valid) begin
            if (m_run >= STARVE_MAX - 1) m_hold = 1'b1;
            m_run++;
        end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        e.rd   = m_rd;
        e.data = m_data;
        e.busy = m_busy;
        e.hold = m_hold;
        expq.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rstn && expq.size() > 0) begin
                e = expq.pop_front();
                chk("rf_we", {31'b0, rf_we}, {31'b0, e.we});
                chk("rf_rd", {27'b0, rf_rd}, {27'b0, e.rd});
                chk("rf_wdata", rf_wdata, e.data);
                chk("busy", busy, e.busy);
                chk("pipe_hold", {31'b0, pipe_hold}, {31'b0, e.hold});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #2;
        if (m_win == 2) mdu_valid = 1'b0;
        if (m_win == 3) lsu_valid = 1'b0;
        pipe_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        pipe_valid  = 0;
        mdu_valid   = 0;
        lsu_valid   = 0;
        issue_valid = 0;
        expq.delete();
        model_reset();
        #1;
        chk("rst_we", {31'b0, rf_we}, 32'd0);
        chk("rst_rd", {27'b0, rf_rd}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_hold", {31'b0, pipe_hold}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        step();
    endtask

    initial begin
        int rate;
        do_reset();

        issue(5'd6);
        chk("issue6_busy", {31'b0, busy[6]}, 32'd1);
        pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hA5;
        mdu_valid  = 1; mdu_rd  = 6; mdu_data  = 32'h66;
        step();
        chk("prio_we", {31'b0, rf_we}, 32'd1);
        chk("prio_rd", {27'b0, rf_rd}, 32'd5);
        chk("prio_data", rf_wdata, 32'hA5);
        step();
        chk("mdu_after_pipe_rd", {27'b0, rf_rd}, 32'd6);
        chk("mdu_clear_busy6", {31'b0, busy[6]}, 32'd0);

        mdu_valid = 1; mdu_rd = 10; mdu_data = 32'h10;
        lsu_valid = 1; lsu_rd = 11; lsu_data = 32'h11;
        issue_valid = 1; issue_rd = 12;
        step();
        do_reset();

        issue(5'd3);
        issue(5'd4);
        mdu_valid = 1; mdu_rd = 3; mdu_data = 32'h33;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
        step();
        chk("rr_first_rd", {27'b0, rf_rd}, 32'd3);
        chk("rr_busy34", {30'b0, busy[4:3]}, 32'd2);
        step();
        chk("rr_second_rd", {27'b0, rf_rd}, 32'd4);
        chk("rr_busy4", {31'b0, busy[4]}, 32'd0);

        issue(5'd7);
        chk("sb_busy7_set", {31'b0, busy[7]}, 32'd1);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
        issue_valid = 1; issue_rd = 7;
        step();
        chk("sb_set_wins", {31'b0, busy[7]}, 32'd1);

        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFF;
        step();
        chk("x0_we", {31'b0, rf_we}, 32'd0);
        chk("x0_data", rf_wdata, 32'hFFFF);

        mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
        for (int i = 0; i < STARVE_MAX; i++) begin
            chk("starve_no_hold", {31'b0, pipe_hold}, 32'd0);
            pipe_valid = 1; pipe_rd = 5'(20 + i); pipe_data = 32'(i);
            step();
        end
        chk("starve_hold", {31'b0, pipe_hold}, 32'd1);
        step();
        chk("starve_mdu_rd", {27'b0, rf_rd}, 32'd9);
        chk("starve_release", {31'b0, pipe_hold}, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            rate = ((c / 400) % 2 == 1) ? 95 : 30;
            if (!m_hold && $urandom_range(0, 99) < rate) begin
                pipe_valid = 1;
                pipe_rd    = 5'($urandom_range(0, 7));
                pipe_data  = $urandom;
            end
            if (!mdu_valid && $urandom_range(0, 3) == 0) begin
                mdu_valid = 1;
                mdu_rd    = 5'($urandom_range(0, 7));
                mdu_data  = $urandom;
            end
            if (!lsu_valid && $urandom_range(0, 3) == 0) begin
                lsu_valid = 1;
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            if (c == 1700) do_reset();
            step();
        end

        step();
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
